// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between CPU port A and a secondary port B,
// with a starvation guard for B and tagged fixed-latency read return.
module mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [15:0]       a_addr,
  input  logic              a_we,
  input  logic [7:0]        a_wdata,
  output logic              a_gnt,
  output logic [7:0]        a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic [15:0]       b_addr,
  input  logic              b_we,
  input  logic [7:0]        b_wdata,
  output logic              b_gnt,
  output logic [7:0]        b_rdata,
  output logic              b_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_do
);
  typedef struct packed {
    logic v;
    logic p;
    logic o;
  } tag_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        a_hold_q, b_hold_q;
  tag_t              tag_q [READ_LAT];
  tag_t              tag_d, tag_out;
  logic              gnt, we, oor;
  logic [15:0]       addr;
  logic [7:0]        rd;
  always_comb begin
    b_gnt    = !rst && b_req && (!a_req || starve_q == LIM);
    a_gnt    = !rst && a_req && !b_gnt;
    gnt      = a_gnt || b_gnt;
    addr     = b_gnt ? b_addr : a_addr;
    we       = b_gnt ? b_we : a_we;
    oor      = (addr >> ADDR_W) != 16'd0;
    ram_we   = gnt && we && !oor;
    ram_di   = !gnt ? 8'h00 : b_gnt ? b_wdata : a_wdata;
    addr_d   = rst ? '0 : gnt ? addr[ADDR_W-1:0] : addr_q;
    ram_addr = addr_d;
    tag_d    = '{v: gnt && !we, p: b_gnt, o: oor};
    starve_d = (rst || !b_req || b_gnt) ? 4'd0 : (starve_q == LIM) ? starve_q : starve_q + 4'd1;
    tag_out  = tag_q[READ_LAT-1];
    rd       = tag_out.o ? 8'hFF : ram_do;
    a_rvalid = !rst && tag_out.v && !tag_out.p;
    b_rvalid = !rst && tag_out.v && tag_out.p;
    a_rdata  = rst ? 8'h00 : a_rvalid ? rd : a_hold_q;
    b_rdata  = rst ? 8'h00 : b_rvalid ? rd : b_hold_q;
  end
  // The tag pipe mirrors the RAM read latency so data is routed to its owner.
  always_ff @(posedge clk) begin
    starve_q <= starve_d;
    addr_q   <= addr_d;
    a_hold_q <= a_rdata;
    b_hold_q <= b_rdata;
    tag_q[0] <= rst ? '0 : tag_d;
    for (int i = 1; i < READ_LAT; i++) tag_q[i] <= rst ? '0 : tag_q[i-1];
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random + directed check of two arbiters (READ_LAT 1 and 2) against a
// behavioural model of grants, memory contents and in-order read returns.
module tb_mem_arbiter;
  localparam int LIM = 4;
  typedef struct packed {
    int         due;
    logic       p;
    logic [7:0] d;
  } ret_t;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0]      a_addr = '0, b_addr = '0;
  logic [7:0]       a_wdata = '0, b_wdata = '0;
  logic [1:0]       a_gnt, b_gnt, a_rv, b_rv, ram_we;
  logic [1:0][7:0]  a_rd, b_rd, ram_di, ram_do;
  logic [1:0][12:0] ram_addr;
  logic [7:0]       mem0 [8192];
  logic [7:0]       mem1 [8192];
  logic [7:0]       sh [8192];
  logic [7:0]       p0, q1a, q1b;
  ret_t             rq [2][$];
  logic [7:0]       ha [2];
  logic [7:0]       hb [2];
  int               bwait = 0, cyc = 0, n_chk = 0, n_pass = 0;
  logic             last_ea = 1'b0, last_eb = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(13), .READ_LAT(1), .STARVE_LIMIT(LIM)) u0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
    .a_gnt(a_gnt[0]), .a_rdata(a_rd[0]), .a_rvalid(a_rv[0]),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
    .b_gnt(b_gnt[0]), .b_rdata(b_rd[0]), .b_rvalid(b_rv[0]),
    .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_di(ram_di[0]), .ram_do(ram_do[0])
  );
  mem_arbiter #(.ADDR_W(13), .READ_LAT(2), .STARVE_LIMIT(LIM)) u1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
    .a_gnt(a_gnt[1]), .a_rdata(a_rd[1]), .a_rvalid(a_rv[1]),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
    .b_gnt(b_gnt[1]), .b_rdata(b_rd[1]), .b_rvalid(b_rv[1]),
    .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_di(ram_di[1]), .ram_do(ram_do[1])
  );

  // Write-first RAMs, latency 1 for u0 and 2 for u1.
  always @(posedge clk) begin
    if (ram_we[0]) mem0[ram_addr[0]] <= ram_di[0];
    if (ram_we[1]) mem1[ram_addr[1]] <= ram_di[1];
    p0  <= ram_we[0] ? ram_di[0] : mem0[ram_addr[0]];
    q1a <= ram_we[1] ? ram_di[1] : mem1[ram_addr[1]];
    q1b <= q1a;
  end
  assign ram_do[0] = p0;
  assign ram_do[1] = q1b;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
  endtask

  task automatic evaluate();
    logic        ea, eb, sw, inr, ev, ep, ewe;
    logic [15:0] sa;
    logic [7:0]  sd, ed, rdat;
    eb  = !rst && b_req && (!a_req || bwait == LIM);
    ea  = !rst && a_req && !eb;
    sa  = eb ? b_addr : a_addr;
    sw  = eb ? b_we : a_we;
    sd  = eb ? b_wdata : a_wdata;
    inr = sa < 16'd8192;
    ewe = (ea || eb) && sw && inr;
    for (int i = 0; i < 2; i++) begin
      ev = 1'b0; ep = 1'b0; ed = 8'h00;
      if (rq[i].size() > 0 && rq[i][0].due == cyc) begin
        ev = !rst; ep = rq[i][0].p; ed = rq[i][0].d;
        void'(rq[i].pop_front());
      end
      if (ev && !ep) ha[i] = ed;
      if (ev && ep) hb[i] = ed;
      if (rst) begin ha[i] = 8'h00; hb[i] = 8'h00; end
      chk("a_gnt", 16'(a_gnt[i]), 16'(ea));
      chk("b_gnt", 16'(b_gnt[i]), 16'(eb));
      chk("ram_we", 16'(ram_we[i]), 16'(ewe));
      if (ea || eb) chk("ram_addr", 16'(ram_addr[i]), 16'(sa[12:0]));
      if (rst) chk("ram_addr_rst", 16'(ram_addr[i]), 16'h0);
      if (ewe) chk("ram_di", 16'(ram_di[i]), 16'(sd));
      chk("a_rvalid", 16'(a_rv[i]), 16'(ev && !ep));
      chk("b_rvalid", 16'(b_rv[i]), 16'(ev && ep));
      chk("a_rdata", 16'(a_rd[i]), 16'(ha[i]));
      chk("b_rdata", 16'(b_rd[i]), 16'(hb[i]));
    end
    if (rst) begin
      rq[0].delete(); rq[1].delete(); bwait = 0;
    end else begin
      bwait = (b_req && !eb) ? ((bwait < LIM) ? bwait + 1 : LIM) : 0;
      if (ewe) sh[sa[12:0]] = sd;
      if ((ea || eb) && !sw) begin
        rdat = inr ? sh[sa[12:0]] : 8'hFF;
        for (int i = 0; i < 2; i++) rq[i].push_back('{due: cyc + i + 1, p: eb, d: rdat});
      end
    end
    last_ea = ea; last_eb = eb;
    cyc++;
  endtask

  task automatic tick(input logic r, input logic ar, input logic [15:0] aa, input logic aw,
                      input logic [7:0] ad, input logic br, input logic [15:0] ba,
                      input logic bw, input logic [7:0] bd);
    @(posedge clk);
    #1;
    rst = r; a_req = ar; a_addr = aa; a_we = aw; a_wdata = ad;
    b_req = br; b_addr = ba; b_we = bw; b_wdata = bd;
    @(negedge clk);
    evaluate();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  // Both ports read continuously from a clean counter: B must win every fifth cycle.
  task automatic starve_run();
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, 1'b1, 16'($urandom_range(0, 8191)), 1'b0, 8'h0,
           1'b1, 16'($urandom_range(0, 8191)), 1'b0, 8'h0);
      chk("starve_seq", 16'(b_gnt[0]), 16'((k % 5) == 4));
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [7:0]  v;
    logic        ar, aw, br, bw, r;
    logic [15:0] aa, ba;
    logic [7:0]  ad, bd;
    for (int j = 0; j < 8192; j++) begin
      v = 8'($urandom);
      mem0[j] = v; mem1[j] = v; sh[j] = v;
    end
    mem0[100] = 8'h37; mem1[100] = 8'h37; sh[100] = 8'h37;
    for (int i = 0; i < 2; i++) begin ha[i] = 8'h00; hb[i] = 8'h00; end
    repeat (2) tick(1'b1, 1'b1, 16'd100, 1'b0, 8'h0, 1'b1, 16'd7, 1'b0, 8'h0);
    tick(1'b0, 1'b1, 16'd100, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    chk("a_read_100", 16'(a_rd[0]), 16'h37);
    idle(2);
    starve_run();
    idle(2);
    tick(1'b0, 1'b1, 16'h0010, 1'b1, 8'h5A, 1'b0, 16'h0, 1'b0, 8'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 16'h0010, 1'b0, 8'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    chk("wr_then_rd", 16'(b_rd[0]), 16'h5A);
    idle(2);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 16'h2005, 1'b1, 8'h99);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 16'h2005, 1'b0, 8'h0);
    chk("oor_ram_kept", 16'(mem0[5]), 16'(sh[5]));
    idle(3);
    chk("oor_rdata", 16'(b_rd[1]), 16'h00FF);
    tick(1'b0, 1'b1, 16'd200, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 16'd300, 1'b0, 8'h0);
    idle(3);
    repeat (2) tick(1'b0, 1'b1, 16'd400, 1'b0, 8'h0, 1'b1, 16'd500, 1'b0, 8'h0);
    tick(1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    idle(3);
    starve_run();
    idle(2);
    repeat (3000) begin
      if (a_req && !last_ea) begin
        ar = a_req; aa = a_addr; aw = a_we; ad = a_wdata;
      end else begin
        ar = 1'($urandom_range(0, 1)); aa = rnd_addr(); aw = 1'($urandom_range(0, 1)); ad = 8'($urandom);
      end
      if (b_req && !last_eb) begin
        br = b_req; ba = b_addr; bw = b_we; bd = b_wdata;
      end else begin
        br = 1'($urandom_range(0, 1)); ba = rnd_addr(); bw = 1'($urandom_range(0, 1)); bd = 8'($urandom);
      end
      r = ($urandom_range(0, 199) == 0);
      tick(r, ar, aa, aw, ad, br, ba, bw, bd);
    end
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8K x 8 synchronous RAM between the CPU (port A) and a second requester (port B, e.g. loader/DMA/debug reader).
- Sits between cpu/ram and a secondary master; CPU normally has priority.
- A starvation counter guarantees port B forward progress.
- Routes read data back to the owning port with a fixed, tagged latency.

Parameters:
- ADDR_W, 13: RAM address width; RAM holds 2^ADDR_W bytes.
- READ_LAT, 1: RAM read latency in cycles (1..4).
- STARVE_LIMIT, 4: consecutive cycles B may wait while A is granted before B is forced (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; held until granted.
- a_addr  in  16  port A byte address.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_wdata  in  8  port A write data.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_rdata  out  8  port A read data.
- a_rvalid  out  1  a_rdata valid, one-cycle pulse.
- b_req, b_addr, b_we, b_wdata, b_gnt, b_rdata, b_rvalid: same as port A, for port B.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_di  out  8  data to RAM.
- ram_do  in  8  data from RAM, valid READ_LAT cycles after a read issue.

Behaviour:
- Reset: while rst=1, a_gnt=b_gnt=0, ram_we=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, starve counter=0, and the latency tag pipe is cleared.
- Reset mid-operation drops in-flight reads: no rvalid is produced for any read issued before reset.
- Throughput: at most one grant per cycle.
- The grant and RAM drive are combinational from the requests in the same cycle. ram_addr, ram_we and ram_di come from the granted port. With no grant, ram_we=0 and ram_addr holds the last value.
- Arbitration:
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant A, unless starve counter = STARVE_LIMIT, in which case grant B.
- Starve counter (4-bit):
  - Increments each cycle b_req=1 and A is granted.
  - Resets to 0 on any B grant or when b_req=0.
  - Saturates at STARVE_LIMIT.
- Address range:
  - In range when addr[15:ADDR_W]==0. Only addr[ADDR_W-1:0] goes to RAM.
  - Out-of-range requests are still granted, but ram_we is forced to 0.
  - An out-of-range read returns 0xFF with normal latency; RAM data is ignored.
- Read return:
  - Each granted read pushes a tag {valid, port, oor} into a READ_LAT-deep shift register.
  - At the pipe output, pulse the owning port's rvalid for one cycle.
  - rdata = ram_do, or 0xFF if oor. The non-owning port's rdata holds its previous value.
  - Writes produce no rvalid.
- Back-to-back reads from alternating ports each return in order, each exactly READ_LAT cycles after its grant.
- A write and a later read to the same address in consecutive cycles return the new data; RAM write-first ordering is handled by the RAM itself.
- No state machine beyond the starve counter and tag pipe. The arbiter is work-conserving: never idle while any req=1.

Test Plan:
- Reset released, A reads addr 100 holding 0x37 (READ_LAT=1) -> a_gnt=1 same cycle, a_rvalid=1 with a_rdata=0x37 next cycle, b_rvalid stays 0.
- A and B both request continuously, STARVE_LIMIT=4 -> grant sequence A,A,A,A,B repeating; B never waits more than 4 cycles.
- A writes 0x5A to addr 0x0010, next cycle B reads 0x0010 -> b_rvalid next cycle with 0x5A.
- B writes 0x99 to addr 0x2005 (out of range) -> b_gnt=1, ram_we=0, RAM unchanged. Then B reads 0x2005 -> b_rdata=0xFF.
- READ_LAT=2: A read at cycle t, B read at t+1 -> a_rvalid at t+2, b_rvalid at t+3, correct data each.
- Issue an A read, assert rst for one cycle before its return -> no a_rvalid, all outputs 0, starve counter 0 after reset.
